// File: rtl/hpc_test_sequencer.sv
// hpc_test_sequencer
// Autonomous Avalon-MM master that drives the testbench register slave in place
// of the HPS. It checks the system version, resets and configures the driver
// filters, enables the run, polls the data counter up to run_length, freezes,
// reads back the counters and finally disables the run.
//
// Optional feature macro: SEQ_ACCURACY_EN. When it is defined, the max/min
// accuracy registers (0x38/0x3C) are also read back. When it is undefined,
// res_maxacc and res_minacc are tied to 0.
//
// Ports
//   clk, reset_n         clock and asynchronous active-low reset
//   start, abort         1-cycle control pulses
//   cfg_fselect          filter select, written to 0x10 bit0
//   cfg_fmanual_a/b      manual filter words, written to 0x14/0x18
//   run_length           target data-counter value
//   master_*             Avalon-MM master; readdata is valid the cycle after read
//   busy, done, error    status (done is a pulse, error is sticky)
//   res_*                counters captured after freeze
module hpc_test_sequencer #(
    parameter logic [31:0] EXP_SYS_VERSION = 32'd20,
    parameter int unsigned POLL_GAP        = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        cfg_fselect,
    input  logic [31:0] cfg_fmanual_a,
    input  logic [31:0] cfg_fmanual_b,
    input  logic [31:0] run_length,
    output logic [5:0]  master_address,
    output logic        master_read,
    output logic        master_write,
    output logic [31:0] master_writedata,
    input  logic [31:0] master_readdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] res_datctr,
    output logic [31:0] res_errctr,
    output logic [31:0] res_maxacc,
    output logic [31:0] res_minacc
);

    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [5:0] A_CTRL = 6'h00;
    localparam logic [5:0] A_VER  = 6'h04;
    localparam logic [5:0] A_FSEL = 6'h10;
    localparam logic [5:0] A_FMA  = 6'h14;
    localparam logic [5:0] A_FMB  = 6'h18;
    localparam logic [5:0] A_DAT  = 6'h30;
    localparam logic [5:0] A_ERR  = 6'h34;
`ifdef SEQ_ACCURACY_EN
    localparam logic [5:0] A_MAX  = 6'h38;
    localparam logic [5:0] A_MIN  = 6'h3C;
`endif

    // Each read state is followed by its own capture state (strobes low).
    typedef enum logic [4:0] {
        S_IDLE,
        S_RD_VER,  S_CAP_VER,
        S_WR_RST,  S_WR_FSEL, S_WR_FMA, S_WR_FMB, S_WR_EN,
        S_POLL_RD, S_POLL_CAP, S_POLL_WAIT,
        S_WR_FRZ,
        S_RD_DAT,  S_CAP_DAT,
        S_RD_ERR,  S_CAP_ERR,
`ifdef SEQ_ACCURACY_EN
        S_RD_MAX,  S_CAP_MAX,
        S_RD_MIN,  S_CAP_MIN,
`endif
        S_WR_OFF,
        S_FIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GAP_W-1:0]   r_gap;
    logic               r_aborted;
    logic               r_fsel;
    logic [31:0]        r_fma;
    logic [31:0]        r_fmb;
    logic [31:0]        r_run_len;
    logic               w_start_ok;
    logic               w_abort_hit;
    logic               w_read;
    logic               w_write;
    logic [5:0]         w_addr;
    logic [31:0]        w_wdata;

    assign w_start_ok  = (r_state == S_IDLE) && start;
    // FIN already carries the done pulse, so abort is no longer honoured there.
    assign w_abort_hit = abort && (r_state != S_IDLE) && (r_state != S_FIN);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_nxt = S_RD_VER;
            S_RD_VER:    w_state_nxt = S_CAP_VER;
            S_CAP_VER:   w_state_nxt = (master_readdata == EXP_SYS_VERSION) ? S_WR_RST : S_IDLE;
            S_WR_RST:    w_state_nxt = S_WR_FSEL;
            S_WR_FSEL:   w_state_nxt = S_WR_FMA;
            S_WR_FMA:    w_state_nxt = S_WR_FMB;
            S_WR_FMB:    w_state_nxt = S_WR_EN;
            S_WR_EN:     w_state_nxt = S_POLL_RD;
            S_POLL_RD:   w_state_nxt = S_POLL_CAP;
            S_POLL_CAP:  w_state_nxt = (master_readdata >= r_run_len) ? S_WR_FRZ : S_POLL_WAIT;
            S_POLL_WAIT: if (r_gap == '0) w_state_nxt = S_POLL_RD;
            S_WR_FRZ:    w_state_nxt = S_RD_DAT;
            S_RD_DAT:    w_state_nxt = S_CAP_DAT;
            S_CAP_DAT:   w_state_nxt = S_RD_ERR;
            S_RD_ERR:    w_state_nxt = S_CAP_ERR;
`ifdef SEQ_ACCURACY_EN
            S_CAP_ERR:   w_state_nxt = S_RD_MAX;
            S_RD_MAX:    w_state_nxt = S_CAP_MAX;
            S_CAP_MAX:   w_state_nxt = S_RD_MIN;
            S_RD_MIN:    w_state_nxt = S_CAP_MIN;
            S_CAP_MIN:   w_state_nxt = S_WR_OFF;
`else
            S_CAP_ERR:   w_state_nxt = S_WR_OFF;
`endif
            S_WR_OFF:    w_state_nxt = r_aborted ? S_IDLE : S_FIN;
            S_FIN:       w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
        // Abort: the current access finishes, then a single disable write.
        if (w_abort_hit) begin
            w_state_nxt = (r_state == S_WR_OFF) ? S_IDLE : S_WR_OFF;
        end
    end

    // Output decode: bus values for the state being entered; address and
    // write data hold through capture and idle cycles.
    always_comb begin
        w_read  = 1'b0;
        w_write = 1'b0;
        w_addr  = master_address;
        w_wdata = master_writedata;
        case (w_state_nxt)
            S_RD_VER:  begin w_read  = 1'b1; w_addr = A_VER;  end
            S_WR_RST:  begin w_write = 1'b1; w_addr = A_CTRL; w_wdata = 32'h1; end
            S_WR_FSEL: begin w_write = 1'b1; w_addr = A_FSEL; w_wdata = {31'b0, r_fsel}; end
            S_WR_FMA:  begin w_write = 1'b1; w_addr = A_FMA;  w_wdata = r_fma; end
            S_WR_FMB:  begin w_write = 1'b1; w_addr = A_FMB;  w_wdata = r_fmb; end
            S_WR_EN:   begin w_write = 1'b1; w_addr = A_CTRL; w_wdata = 32'h2; end
            S_POLL_RD: begin w_read  = 1'b1; w_addr = A_DAT;  end
            S_WR_FRZ:  begin w_write = 1'b1; w_addr = A_CTRL; w_wdata = 32'h6; end
            S_RD_DAT:  begin w_read  = 1'b1; w_addr = A_DAT;  end
            S_RD_ERR:  begin w_read  = 1'b1; w_addr = A_ERR;  end
`ifdef SEQ_ACCURACY_EN
            S_RD_MAX:  begin w_read  = 1'b1; w_addr = A_MAX;  end
            S_RD_MIN:  begin w_read  = 1'b1; w_addr = A_MIN;  end
`endif
            S_WR_OFF:  begin w_write = 1'b1; w_addr = A_CTRL; w_wdata = 32'h0; end
            default:   ;
        endcase
    end

    // Registered bus outputs, status, sampled config and poll gap counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            r_aborted        <= 1'b0;
            r_gap            <= '0;
            r_fsel           <= 1'b0;
            r_fma            <= '0;
            r_fmb            <= '0;
            r_run_len        <= '0;
        end else begin
            master_read      <= w_read;
            master_write     <= w_write;
            master_address   <= w_addr;
            master_writedata <= w_wdata;
            busy             <= (w_state_nxt != S_IDLE);
            done             <= (w_state_nxt == S_FIN);
            if (w_start_ok) begin
                r_fsel    <= cfg_fselect;
                r_fma     <= cfg_fmanual_a;
                r_fmb     <= cfg_fmanual_b;
                r_run_len <= run_length;
                r_aborted <= 1'b0;
                error     <= 1'b0;
            end else if (w_abort_hit) begin
                r_aborted <= 1'b1;
            end
            // Any return to IDLE that is not through FIN is a failed run.
            if ((r_state != S_IDLE) && (r_state != S_FIN) && (w_state_nxt == S_IDLE)) begin
                error <= 1'b1;
            end
            if (r_state == S_POLL_CAP) begin
                r_gap <= GAP_W'(POLL_GAP - 1);
            end else if (r_state == S_POLL_WAIT) begin
                r_gap <= r_gap - GAP_W'(1);
            end
        end
    end

    // Result capture; a capture cycle hit by abort is discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_datctr <= '0;
            res_errctr <= '0;
        end else if (!w_abort_hit) begin
            if (r_state == S_CAP_DAT) res_datctr <= master_readdata;
            if (r_state == S_CAP_ERR) res_errctr <= master_readdata;
        end
    end

`ifdef SEQ_ACCURACY_EN
    logic [31:0] r_res_max;
    logic [31:0] r_res_min;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res_max <= '0;
            r_res_min <= '0;
        end else if (!w_abort_hit) begin
            if (r_state == S_CAP_MAX) r_res_max <= master_readdata;
            if (r_state == S_CAP_MIN) r_res_min <= master_readdata;
        end
    end

    assign res_maxacc = r_res_max;
    assign res_minacc = r_res_min;
`else
    assign res_maxacc = 32'd0;
    assign res_minacc = 32'd0;
`endif

endmodule

// File: tb/tb_hpc_test_sequencer.sv
// Directed bench for hpc_test_sequencer with a small register-slave model.
`timescale 1ns/1ps
module tb_hpc_test_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        cfg_fselect;
    logic [31:0] cfg_fmanual_a;
    logic [31:0] cfg_fmanual_b;
    logic [31:0] run_length;
    logic [5:0]  master_address;
    logic        master_read;
    logic        master_write;
    logic [31:0] master_writedata;
    logic [31:0] master_readdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] res_datctr;
    logic [31:0] res_errctr;
    logic [31:0] res_maxacc;
    logic [31:0] res_minacc;

    always #5 clk = ~clk;

    hpc_test_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .abort            (abort),
        .cfg_fselect      (cfg_fselect),
        .cfg_fmanual_a    (cfg_fmanual_a),
        .cfg_fmanual_b    (cfg_fmanual_b),
        .run_length       (run_length),
        .master_address   (master_address),
        .master_read      (master_read),
        .master_write     (master_write),
        .master_writedata (master_writedata),
        .master_readdata  (master_readdata),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .res_datctr       (res_datctr),
        .res_errctr       (res_errctr),
        .res_maxacc       (res_maxacc),
        .res_minacc       (res_minacc)
    );

    // Slave model: data counter increments on each 0x30 read while enabled.
    logic [31:0] m_ver;
    logic [31:0] m_err;
    logic [31:0] m_max;
    logic [31:0] m_min;
    logic [31:0] m_dat;
    logic        m_en;
    logic [31:0] m_rdata;

    always @(posedge clk) begin
        if (master_write && master_address == 6'h00) begin
            if (master_writedata == 32'h1) m_dat <= 32'h0;
            m_en <= (master_writedata == 32'h2);
        end
        if (master_read) begin
            case (master_address)
                6'h04: m_rdata <= m_ver;
                6'h30: begin
                    m_rdata <= m_dat;
                    if (m_en) m_dat <= m_dat + 32'h1;
                end
                6'h34: m_rdata <= m_err;
                6'h38: m_rdata <= m_max;
                6'h3C: m_rdata <= m_min;
                default: m_rdata <= 32'hBAD0_0000;
            endcase
        end
    end
    assign master_readdata = m_rdata;

    // Bus monitor: access log, 0x30 read times, done cycles, strobe overlap.
    typedef struct packed {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } acc_t;

    function automatic acc_t mk(input logic wr, input logic [5:0] a, input logic [31:0] d);
        acc_t r;
        r.wr = wr; r.addr = a; r.data = d;
        return r;
    endfunction

    acc_t log_q[$];
    int   poll_t[$];
    int   cyc      = 0;
    int   done_cnt = 0;
    int   both_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (master_read && master_write) both_cnt <= both_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (master_write) begin
            log_q.push_back(mk(1'b1, master_address, master_writedata));
        end else if (master_read) begin
            log_q.push_back(mk(1'b0, master_address, 32'h0));
            if (master_address == 6'h30) poll_t.push_back(cyc);
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    // Full successful run; cfg and run_length are changed mid-run to show they were sampled.
    task automatic normal_run(input string pfx);
        acc_t exp_q[$];
        int   idx;
        int   pidx;
        int   d0;
        exp_q = {};
        exp_q.push_back(mk(1'b0, 6'h04, 32'h0));
        exp_q.push_back(mk(1'b1, 6'h00, 32'h1));
        exp_q.push_back(mk(1'b1, 6'h10, 32'h1));
        exp_q.push_back(mk(1'b1, 6'h14, 32'hDEAD_BEEF));
        exp_q.push_back(mk(1'b1, 6'h18, 32'h1234_5678));
        exp_q.push_back(mk(1'b1, 6'h00, 32'h2));
        for (int i = 0; i < 6; i++) exp_q.push_back(mk(1'b0, 6'h30, 32'h0));
        exp_q.push_back(mk(1'b1, 6'h00, 32'h6));
        exp_q.push_back(mk(1'b0, 6'h30, 32'h0));
        exp_q.push_back(mk(1'b0, 6'h34, 32'h0));
`ifdef SEQ_ACCURACY_EN
        exp_q.push_back(mk(1'b0, 6'h38, 32'h0));
        exp_q.push_back(mk(1'b0, 6'h3C, 32'h0));
`endif
        exp_q.push_back(mk(1'b1, 6'h00, 32'h0));

        m_ver = 32'd20;
        cfg_fselect   = 1'b1;
        cfg_fmanual_a = 32'hDEAD_BEEF;
        cfg_fmanual_b = 32'h1234_5678;
        run_length    = 32'd5;
        idx  = log_q.size();
        pidx = poll_t.size();
        d0   = done_cnt;
        pulse_start();
        check({pfx, "_busy_on"}, 64'(busy), 64'd1);
        check({pfx, "_err_clr"}, 64'(error), 64'd0);
        cfg_fmanual_b = 32'hFFFF_0000;
        run_length    = 32'd0;
        repeat (4) @(posedge clk);
        #1;
        pulse_start();
        wait_idle(400);
        check({pfx, "_n_acc"}, 64'(log_q.size() - idx), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            check($sformatf("%s_acc%0d", pfx, i), 64'(log_q[idx + i]), 64'(exp_q[i]));
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_gap%0d", pfx, i), 64'(poll_t[pidx + i + 1] - poll_t[pidx + i]), 64'd18);
        end
        check({pfx, "_done"},   64'(done_cnt - d0), 64'd1);
        check({pfx, "_error"},  64'(error), 64'd0);
        check({pfx, "_datctr"}, 64'(res_datctr), 64'd6);
        check({pfx, "_errctr"}, 64'(res_errctr), 64'd3);
`ifdef SEQ_ACCURACY_EN
        check({pfx, "_maxacc"}, 64'(res_maxacc), 64'h40);
        check({pfx, "_minacc"}, 64'(res_minacc), 64'h02);
`else
        check({pfx, "_maxacc"}, 64'(res_maxacc), 64'h0);
        check({pfx, "_minacc"}, 64'(res_minacc), 64'h0);
`endif
        @(posedge clk); #1;
        check({pfx, "_no_restart"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int idx;
        int d0;
        int n;
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_fselect = 1'b0;
        cfg_fmanual_a = 32'h0;
        cfg_fmanual_b = 32'h0;
        run_length = 32'h0;
        m_ver = 32'd20;
        m_err = 32'd3;
        m_max = 32'h40;
        m_min = 32'h02;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_read",  64'(master_read), 64'd0);
        check("rst_write", 64'(master_write), 64'd0);
        check("rst_addr",  64'(master_address), 64'd0);
        check("rst_wdata", 64'(master_writedata), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_dat",   64'(res_datctr), 64'd0);
        check("rst_err",   64'(res_errctr), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Version mismatch: one read, then error
        m_ver = 32'd19;
        idx = log_q.size();
        d0  = done_cnt;
        pulse_start();
        wait_idle(50);
        check("ver_n_acc", 64'(log_q.size() - idx), 64'd1);
        check("ver_acc0",  64'(log_q[idx]), 64'(mk(1'b0, 6'h04, 32'h0)));
        check("ver_error", 64'(error), 64'd1);
        check("ver_done",  64'(done_cnt - d0), 64'd0);

        // Normal run (clears error on accepted start)
        normal_run("run1");

        // Abort while idle is ignored
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;
        check("idle_abort_err",  64'(error), 64'd0);
        check("idle_abort_busy", 64'(busy), 64'd0);

        // Start+abort together while idle: start wins; then abort in a poll capture
        m_ver = 32'd20;
        run_length = 32'd1000;
        d0 = done_cnt;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy",  64'(busy), 64'd1);
        check("sa_error", 64'(error), 64'd0);
        n = 0;
        for (int i = 0; i < 500 && n < 3; i++) begin
            @(posedge clk); #1;
            if (master_read && master_address == 6'h30) n++;
        end
        check("ab_polls", 64'(n), 64'd3);
        @(posedge clk); #1;
        check("ab_in_cap", 64'(master_read), 64'd0);
        idx = log_q.size();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle(50);
        check("ab_n_acc", 64'(log_q.size() - idx), 64'd1);
        check("ab_acc0",  64'(log_q[idx]), 64'(mk(1'b1, 6'h00, 32'h0)));
        check("ab_error", 64'(error), 64'd1);
        check("ab_done",  64'(done_cnt - d0), 64'd0);
        check("ab_dat",   64'(res_datctr), 64'd6);

        // Reset while a write is on the bus
        run_length = 32'd5;
        pulse_start();
        n = 0;
        while (!master_write && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rw_found", 64'(master_write), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rw_write", 64'(master_write), 64'd0);
        check("rw_read",  64'(master_read), 64'd0);
        check("rw_addr",  64'(master_address), 64'd0);
        check("rw_wdata", 64'(master_writedata), 64'd0);
        check("rw_busy",  64'(busy), 64'd0);
        check("rw_error", 64'(error), 64'd0);
        check("rw_dat",   64'(res_datctr), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        normal_run("run2");

        check("bus_overlap", 64'(both_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
